serial_logic_proc: RTL and testbench
====================================

SERIAL_LOGIC_PROC -- requirements
Module: serial_logic_proc

Interface
REQ-001 Parameter WIDTH, default 8: data width of the A and B registers and of Din.
REQ-002 Parameter DIGIT, default 1: bits processed per clock; WIDTH mod DIGIT SHALL be 0, otherwise elaboration error.
REQ-003 Derived constant NCYC = WIDTH/DIGIT: shift cycles per operation; CW = $clog2(NCYC+1).
REQ-004 Clk  in  1  single clock, all state on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 LoadA  in  1  level; load Din into A while IDLE.
REQ-007 LoadB  in  1  level; load Din into B while IDLE.
REQ-008 Execute  in  1  level; a rising edge starts one operation.
REQ-009 Din  in  WIDTH  load data.
REQ-010 F  in  3  function select: 000 AND, 001 OR, 010 XOR, 011 ones, 100 NAND, 101 NOR, 110 XNOR, 111 zeros.
REQ-011 R  in  2  routing: 00 A,B keep; 01 B<=F(A,B); 10 A<=F(A,B); 11 swap A,B.
REQ-012 Aval  out  WIDTH  register A.
REQ-013 Bval  out  WIDTH  register B.
REQ-014 Busy  out  1  high in SHIFT.
REQ-015 Done  out  1  one-cycle pulse when an operation completes.
REQ-016 Zero  out  1  the F(A,B) word of the last completed operation was all zeros.
REQ-017 Count  out  CW  digits processed in the current operation; 0 when idle.

Function
REQ-018 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-019 Execute SHALL be registered once; the start condition is Execute=1 with the registered copy =0, evaluated only in IDLE.
REQ-020 IDLE->SHIFT on start; F and R SHALL be sampled into internal registers on that edge and held for the whole operation.
REQ-021 In IDLE without start, LoadA/LoadB SHALL load Din on the next edge; both asserted SHALL load both registers.
REQ-022 When start coincides with LoadA/LoadB, start SHALL win and the loads are dropped.
REQ-023 Each SHIFT cycle: A and B rotate right by DIGIT; the shifted-in DIGIT MSBs SHALL be the routed digits computed from the current DIGIT LSBs of A and B.
REQ-024 Per-digit routing: R=00 A<-a, B<-b; 01 A<-a, B<-f; 10 A<-f, B<-b; 11 A<-b, B<-a.
REQ-025 Count SHALL increment each SHIFT cycle; SHIFT->DONE when Count reaches NCYC.
REQ-026 Latency: Aval/Bval SHALL hold the final result NCYC cycles after the start edge; Done SHALL be high in the following cycle (DONE state); DONE->IDLE unconditionally.
REQ-027 Zero SHALL update at entry to DONE to NOR of all f digits computed during the operation.
REQ-028 LoadA, LoadB, F, R and Execute edges SHALL be ignored in SHIFT and DONE; an Execute edge in those states SHALL NOT be queued.
REQ-029 Execute held high across DONE->IDLE SHALL NOT start a new operation; a release and re-press is required.
REQ-030 Arithmetic is bitwise only; no carries cross digit boundaries.

Reset
REQ-031 Reset SHALL immediately force state IDLE, A=0, B=0, Count=0, Busy=0, Done=0, Zero=0, registered Execute=0, sampled F/R=0.
REQ-032 Reset asserted mid-SHIFT SHALL abort the operation with no Done pulse; partial results are discarded.

Structure
REQ-033 Package serial_logic_pkg SHALL hold the state enum, F-code and R-code enums or constants, and the NCYC/CW helper functions.
REQ-034 One sub-module, logic_digit_unit, SHALL be combinational: DIGIT-wide a, b, F, R in; f, routed A/B digits out.
REQ-035 The FSM, counter and shift registers SHALL live in serial_logic_proc.

Verification
REQ-036 WIDTH=8, DIGIT=1: load A=0x33, B=0x55; F=010, R=10, pulse Execute -> Busy high for 8 cycles, then A=0x66, B=0x55, Done pulse in cycle 9, Zero=0.
REQ-037 Continue with F=110, R=01, re-press Execute -> A=0x66, B=0xCC; then R=11 -> A=0xCC, B=0x66.
REQ-038 WIDTH=8, DIGIT=4: same first operation -> result A=0x66 after 2 cycles, Done in cycle 3.
REQ-039 F=111, R=10 with A=0xFF -> A=0x00, Zero=1; LoadA with Din=0xAA during Busy -> A unaffected.
REQ-040 Reset asserted in SHIFT cycle 4 -> A=B=0, Count=0, no Done; Execute held high after the operation completes -> exactly one Done pulse.

Source files
------------

// File: rtl/serial_logic_pkg.sv
// Shared types and sizing helpers for the digit-serial bitwise logic processor.
package serial_logic_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  // Bit 2 inverts the base function selected by bits [1:0].
  typedef enum logic [2:0] {
    F_AND   = 3'b000,
    F_OR    = 3'b001,
    F_XOR   = 3'b010,
    F_ONES  = 3'b011,
    F_NAND  = 3'b100,
    F_NOR   = 3'b101,
    F_XNOR  = 3'b110,
    F_ZEROS = 3'b111
  } f_code_e;

  typedef enum logic [1:0] {
    R_KEEP = 2'b00,
    R_TO_B = 2'b01,
    R_TO_A = 2'b10,
    R_SWAP = 2'b11
  } r_code_e;

  function automatic int calc_ncyc(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int calc_cw(input int ncyc);
    return $clog2(ncyc + 1);
  endfunction

endpackage

// File: rtl/logic_digit_unit.sv
// Combinational per-digit logic: computes f = F(a,b) and the routed A/B digits.
module logic_digit_unit
  import serial_logic_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  f_code_e          f_sel,
  input  r_code_e          r_sel,
  output logic [DIGIT-1:0] f_dig,
  output logic [DIGIT-1:0] a_out,
  output logic [DIGIT-1:0] b_out
);

  always_comb begin
    f_dig = '0;
    case (f_sel)
      F_AND:   f_dig = a & b;
      F_OR:    f_dig = a | b;
      F_XOR:   f_dig = a ^ b;
      F_ONES:  f_dig = '1;
      F_NAND:  f_dig = ~(a & b);
      F_NOR:   f_dig = ~(a | b);
      F_XNOR:  f_dig = ~(a ^ b);
      F_ZEROS: f_dig = '0;
      default: f_dig = '0;
    endcase
  end

  always_comb begin
    a_out = a;
    b_out = b;
    case (r_sel)
      R_KEEP: begin a_out = a;     b_out = b;     end
      R_TO_B: begin a_out = a;     b_out = f_dig; end
      R_TO_A: begin a_out = f_dig; b_out = b;     end
      R_SWAP: begin a_out = b;     b_out = a;     end
      default: begin a_out = a;    b_out = b;     end
    endcase
  end

endmodule

// File: rtl/serial_logic_proc.sv
// Digit-serial bitwise logic processor: A and B rotate right one digit per
// cycle, with the incoming MSB digits taken from the routed logic result.
//
// state   | meaning
// S_IDLE  | waiting; loads accepted, Execute rising edge starts an operation
// S_SHIFT | one digit of A/B processed per cycle, Busy high
// S_DONE  | one-cycle Done pulse, Zero valid, then back to idle
module serial_logic_proc
  import serial_logic_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DIGIT = 1,
  localparam int NCYC  = calc_ncyc(WIDTH, DIGIT),
  localparam int CW    = calc_cw(NCYC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             execute,
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       f,
  input  logic [1:0]       r,
  output logic [WIDTH-1:0] aval,
  output logic [WIDTH-1:0] bval,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic [CW-1:0]    count
);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_logic_proc: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    count_q;
  logic             exec_q;
  logic             any_one_q;
  logic             zero_q;
  f_code_e          f_q;
  r_code_e          r_q;

  logic             start;
  logic             last;
  logic [DIGIT-1:0] f_dig, a_new, b_new;
  logic [WIDTH+DIGIT-1:0] a_cat, b_cat;

  assign start = (state_q == S_IDLE) && execute && !exec_q;
  assign last  = (count_q == CW'(NCYC - 1));

  logic_digit_unit #(.DIGIT(DIGIT)) u_digit (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .f_sel (f_q),
    .r_sel (r_q),
    .f_dig (f_dig),
    .a_out (a_new),
    .b_out (b_new)
  );

  // Concatenate-and-drop keeps the rotate legal even when DIGIT == WIDTH.
  assign a_cat = {a_new, a_q};
  assign b_cat = {b_new, b_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      count_q   <= '0;
      exec_q    <= 1'b0;
      any_one_q <= 1'b0;
      zero_q    <= 1'b0;
      f_q       <= F_AND;
      r_q       <= R_KEEP;
    end else begin
      state_q <= state_d;
      // Tracked in every state so a press during an operation is never queued.
      exec_q  <= execute;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            f_q       <= f_code_e'(f);
            r_q       <= r_code_e'(r);
            count_q   <= '0;
            any_one_q <= 1'b0;
          end else begin
            if (load_a) a_q <= din;
            if (load_b) b_q <= din;
          end
        end
        S_SHIFT: begin
          a_q       <= a_cat[WIDTH+DIGIT-1:DIGIT];
          b_q       <= b_cat[WIDTH+DIGIT-1:DIGIT];
          count_q   <= count_q + CW'(1);
          any_one_q <= any_one_q | (|f_dig);
          if (last) zero_q <= ~(any_one_q | (|f_dig));
        end
        S_DONE: begin
          count_q <= '0;
        end
        default: begin
          count_q <= '0;
        end
      endcase
    end
  end

  assign aval  = a_q;
  assign bval  = b_q;
  assign busy  = (state_q == S_SHIFT);
  assign done  = (state_q == S_DONE);
  assign zero  = zero_q;
  assign count = count_q;

endmodule

// File: tb/tb_serial_logic_proc.sv
// Directed bench for serial_logic_proc: DIGIT=1 and DIGIT=4 instances share stimulus.
module tb_serial_logic_proc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_a = 1'b0;
  logic       load_b = 1'b0;
  logic       execute = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] f = 3'b000;
  logic [1:0] r = 2'b00;

  logic [7:0] aval1, bval1, aval4, bval4;
  logic       busy1, done1, zero1, busy4, done4, zero4;
  logic [3:0] count1;
  logic [1:0] count4;

  int n_tests = 0;
  int n_fail  = 0;

  int b1, d1n, d1at, b4, d4n, d4at;
  logic [3:0] c1;
  logic [1:0] c4;

  always #5 clk = ~clk;

  serial_logic_proc #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .reset(reset), .load_a(load_a), .load_b(load_b), .execute(execute),
    .din(din), .f(f), .r(r), .aval(aval1), .bval(bval1), .busy(busy1),
    .done(done1), .zero(zero1), .count(count1)
  );

  serial_logic_proc #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .reset(reset), .load_a(load_a), .load_b(load_b), .execute(execute),
    .din(din), .f(f), .r(r), .aval(aval4), .bval(bval4), .busy(busy4),
    .done(done4), .zero(zero4), .count(count4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ab(input logic [7:0] av, input logic [7:0] bv);
    load_a = 1'b1; din = av; step();
    load_a = 1'b0; load_b = 1'b1; din = bv; step();
    load_b = 1'b0;
  endtask

  // Starts one operation and watches both instances for 14 cycles; F/R are
  // disturbed mid-operation, and optionally LoadA is pulsed while both are busy.
  task automatic run_op(input logic [2:0] fv, input logic [1:0] rv,
                        input bit hold, input bit load_mid);
    b1 = 0; d1n = 0; d1at = -1; c1 = '0;
    b4 = 0; d4n = 0; d4at = -1; c4 = '0;
    f = fv; r = rv; execute = 1'b1;
    step();
    load_a = 1'b0;
    if (!hold) execute = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (busy1) b1++;
      if (done1) begin d1n++; if (d1at < 0) d1at = k; c1 = count1; end
      if (busy4) b4++;
      if (done4) begin d4n++; if (d4at < 0) d4at = k; c4 = count4; end
      if (k == 1) begin
        f = ~fv; r = ~rv;
        if (load_mid) begin load_a = 1'b1; din = 8'hAA; end
      end
      if (k == 2) load_a = 1'b0;
      step();
    end
    execute = 1'b0; f = fv; r = rv;
    step();
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if ({aval1, bval1} !== 16'h0000) begin n_fail++; $display("FAIL reset_ab1: got %h/%h expected 00/00", aval1, bval1); end
    n_tests++; if ({busy1, done1, zero1, count1} !== 7'b0) begin n_fail++; $display("FAIL reset_flags1: got busy=%b done=%b zero=%b count=%0d expected all 0", busy1, done1, zero1, count1); end
    n_tests++; if ({aval4, bval4, busy4, done4, zero4, count4} !== 21'b0) begin n_fail++; $display("FAIL reset_dut4: got a=%h b=%h busy=%b done=%b zero=%b count=%0d expected all 0", aval4, bval4, busy4, done4, zero4, count4); end
    @(posedge clk); #1; reset = 1'b0;
    step();
  endtask

  task automatic test_load();
    load_ab(8'h33, 8'h55);
    n_tests++; if ({aval1, bval1} !== 16'h3355) begin n_fail++; $display("FAIL load1: got %h/%h expected 33/55", aval1, bval1); end
    n_tests++; if ({aval4, bval4} !== 16'h3355) begin n_fail++; $display("FAIL load4: got %h/%h expected 33/55", aval4, bval4); end
  endtask

  task automatic test_xor();
    run_op(3'b010, 2'b10, 1'b0, 1'b0);
    n_tests++; if (b1 !== 8) begin n_fail++; $display("FAIL xor_busy1: got %0d cycles expected 8", b1); end
    n_tests++; if (d1at !== 8 || d1n !== 1) begin n_fail++; $display("FAIL xor_done1: got at=%0d n=%0d expected at=8 n=1", d1at, d1n); end
    n_tests++; if (c1 !== 4'd8) begin n_fail++; $display("FAIL xor_count1: got %0d expected 8", c1); end
    n_tests++; if ({aval1, bval1, zero1} !== {16'h6655, 1'b0}) begin n_fail++; $display("FAIL xor_res1: got %h/%h z=%b expected 66/55 z=0", aval1, bval1, zero1); end
    n_tests++; if (b4 !== 2 || d4at !== 2 || d4n !== 1 || c4 !== 2'd2) begin n_fail++; $display("FAIL xor_timing4: got busy=%0d at=%0d n=%0d cnt=%0d expected 2/2/1/2", b4, d4at, d4n, c4); end
    n_tests++; if ({aval4, bval4, zero4} !== {16'h6655, 1'b0}) begin n_fail++; $display("FAIL xor_res4: got %h/%h z=%b expected 66/55 z=0", aval4, bval4, zero4); end
    n_tests++; if (count1 !== 4'd0 || count4 !== 2'd0) begin n_fail++; $display("FAIL idle_count: got %0d/%0d expected 0/0", count1, count4); end
  endtask

  task automatic test_xnor_to_b();
    run_op(3'b110, 2'b01, 1'b0, 1'b0);
    n_tests++; if ({aval1, bval1, zero1} !== {16'h66CC, 1'b0}) begin n_fail++; $display("FAIL xnor_res1: got %h/%h z=%b expected 66/CC z=0", aval1, bval1, zero1); end
    n_tests++; if ({aval4, bval4} !== 16'h66CC) begin n_fail++; $display("FAIL xnor_res4: got %h/%h expected 66/CC", aval4, bval4); end
  endtask

  task automatic test_swap();
    run_op(3'b110, 2'b11, 1'b0, 1'b0);
    n_tests++; if ({aval1, bval1} !== 16'hCC66) begin n_fail++; $display("FAIL swap_res1: got %h/%h expected CC/66", aval1, bval1); end
    n_tests++; if ({aval4, bval4} !== 16'hCC66) begin n_fail++; $display("FAIL swap_res4: got %h/%h expected CC/66", aval4, bval4); end
  endtask

  task automatic test_zero_and_busy_load();
    load_a = 1'b1; din = 8'hFF; step(); load_a = 1'b0;
    run_op(3'b111, 2'b10, 1'b0, 1'b1);
    n_tests++; if ({aval1, bval1, zero1} !== {16'h0066, 1'b1}) begin n_fail++; $display("FAIL zeros_res1: got %h/%h z=%b expected 00/66 z=1", aval1, bval1, zero1); end
    n_tests++; if ({aval4, bval4, zero4} !== {16'h0066, 1'b1}) begin n_fail++; $display("FAIL zeros_res4: got %h/%h z=%b expected 00/66 z=1", aval4, bval4, zero4); end
  endtask

  task automatic test_start_wins();
    load_ab(8'h0F, 8'hF0);
    load_a = 1'b1; din = 8'h11;
    run_op(3'b000, 2'b00, 1'b0, 1'b0);
    n_tests++; if ({aval1, bval1, zero1} !== {16'h0FF0, 1'b1}) begin n_fail++; $display("FAIL start_wins1: got %h/%h z=%b expected 0F/F0 z=1", aval1, bval1, zero1); end
    n_tests++; if (d1n !== 1 || {aval4, bval4} !== 16'h0FF0) begin n_fail++; $display("FAIL start_wins4: got done1_n=%0d a4=%h b4=%h expected 1 0F F0", d1n, aval4, bval4); end
  endtask

  task automatic test_held_execute();
    run_op(3'b010, 2'b10, 1'b1, 1'b0);
    n_tests++; if (d1n !== 1) begin n_fail++; $display("FAIL held_done1: got %0d pulses expected 1", d1n); end
    n_tests++; if (d4n !== 1) begin n_fail++; $display("FAIL held_done4: got %0d pulses expected 1", d4n); end
    n_tests++; if ({aval1, bval1} !== 16'hFFF0) begin n_fail++; $display("FAIL held_res1: got %h/%h expected FF/F0", aval1, bval1); end
  endtask

  task automatic test_reset_mid();
    int dn;
    load_ab(8'h5A, 8'h3C);
    f = 3'b010; r = 2'b10; execute = 1'b1;
    step();
    execute = 1'b0;
    step(); step(); step();
    n_tests++; if (busy1 !== 1'b1 || count1 !== 4'd3) begin n_fail++; $display("FAIL mid_pre: got busy=%b count=%0d expected 1/3", busy1, count1); end
    reset = 1'b1;
    #1;
    n_tests++; if ({aval1, bval1, count1, busy1, done1, zero1} !== 23'b0) begin n_fail++; $display("FAIL mid_reset1: got a=%h b=%h cnt=%0d busy=%b done=%b zero=%b expected all 0", aval1, bval1, count1, busy1, done1, zero1); end
    n_tests++; if ({aval4, bval4} !== 16'h0000) begin n_fail++; $display("FAIL mid_reset4: got %h/%h expected 00/00", aval4, bval4); end
    @(posedge clk); #1; reset = 1'b0;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      if (done1 || done4) dn++;
      step();
    end
    n_tests++; if (dn !== 0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL mid_no_done: got %0d done cycles busy=%b expected 0/0", dn, busy1); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_xor();
    test_xnor_to_b();
    test_swap();
    test_zero_and_busy_load();
    test_start_wins();
    test_held_execute();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
